// File: rtl/rom_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : rom_burst_reader
//  Description : Burst read initiator for a single-port synchronous ROM with
//                1-cycle read latency; streams words out through a 2-entry
//                skid FIFO on a valid/ready interface with backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_burst_reader #(
    parameter int WIDTH      = 16,
    parameter int ADDRWIDTH  = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDRWIDTH-1:0] base_addr,
    input  logic [ADDRWIDTH:0]   length,
    output logic                 busy,
    output logic                 done,
    output logic                 rom_en,
    output logic [ADDRWIDTH-1:0] rom_addr,
    input  logic [WIDTH-1:0]     rom_dout,
    output logic [WIDTH-1:0]     m_data,
    output logic                 m_valid,
    input  logic                 m_ready
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW:0]   c_depth_ext = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] c_full      = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDRWIDTH-1:0]   base_q, base_d;
    logic [ADDRWIDTH:0]     len_q, len_d;
    logic [ADDRWIDTH:0]     issued_q, issued_d;
    logic [ADDRWIDTH:0]     returned_q, returned_d;
    logic                   inflight_q, inflight_d;
    logic [CW-1:0]          count_q, count_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]       mem_q [FIFO_DEPTH];
    logic [WIDTH-1:0]       mem_d [FIFO_DEPTH];

    logic                   pop;
    logic                   push;
    logic                   issue;
    logic [CW:0]            occupancy;

    // Stream side, FIFO head, handshake and issue gating
    always_comb begin
        m_valid   = (count_q != '0);
        m_data    = mem_q[rd_ptr_q];
        pop       = m_valid & m_ready;
        push      = inflight_q;
        // Slots already committed: stored words plus the word still in the
        // ROM pipeline, less the one leaving this cycle.
        occupancy = {1'b0, count_q} + (CW + 1)'(inflight_q) - (CW + 1)'(pop);
        issue     = (state_q == S_FETCH) && (issued_q < len_q) && (occupancy < c_depth_ext);
        rom_en    = issue;
        rom_addr  = issue ? (base_q + issued_q[ADDRWIDTH-1:0]) : '0;
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_FINISH);
    end

    // Next-state: FSM, counters and FIFO bookkeeping
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        issued_d   = issued_q;
        returned_d = returned_q;
        inflight_d = issue;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_d      = mem_q;

        if (push) begin
            mem_d[wr_ptr_q] = rom_dout;
            wr_ptr_d        = wr_ptr_q + 1'b1;
            returned_d      = returned_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
        if (issue) begin
            issued_d = issued_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d     = base_addr;
                    len_d      = length;
                    issued_d   = '0;
                    returned_d = '0;
                    state_d    = (length == '0) ? S_FINISH : S_FETCH;
                end
            end
            S_FETCH: begin
                if (issue && (issued_d == len_q)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((returned_d == len_q) && (count_d == '0)) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            returned_q <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            returned_q <= returned_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_q      <= mem_d;
        end
    end

    // The issue gating must make a push into a full FIFO impossible
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count_q == c_full)));

endmodule
`default_nettype wire
